// File: rtl/ethernet_frame_filter_if.sv
// Bus between the byte receiver, the Ethernet receive filter and its payload consumer.
interface ethernet_frame_filter_if;
    // Strobe semantics: byte_valid and out_valid are single-cycle qualifiers with no
    // ready; every asserted cycle carries exactly one byte and must be taken by the sink.
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        rx_dv;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        frame_done;
    logic        frame_ok;
    logic [10:0] frame_len;
    logic [15:0] ethertype;
    logic [15:0] good_count;
    logic [15:0] bad_count;

    modport master (
        output byte_valid, byte_data, rx_dv,
        input  out_valid, out_data, out_sof, frame_done, frame_ok, frame_len,
        input  ethertype, good_count, bad_count
    );

    modport slave (
        input  byte_valid, byte_data, rx_dv,
        output out_valid, out_data, out_sof, frame_done, frame_ok, frame_len,
        output ethertype, good_count, bad_count
    );
endinterface

// File: rtl/ethernet_frame_filter.sv
// Ethernet receive filter: destination/length/CRC-32 checks, FCS-stripped payload
// forwarding, one-cycle verdict and saturating good/bad frame counters.
module ethernet_frame_filter #(
    parameter logic [47:0] MAC_ADDR         = 48'h02_00_00_00_00_01,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter int          MIN_LEN          = 64,
    parameter int          MAX_LEN          = 1518
) (
    input  logic                  clk,
    input  logic                  reset,
    ethernet_frame_filter_if.slave bus,
    output logic [2:0]            dbg_state_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] N_SAT       = 11'd2047;
    localparam logic [10:0] MIN_LEN_N   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_N   = 11'(MAX_LEN);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    logic             dv_meta_q, dv_s_q, dv_prev_q;
    logic [2:0]       state_q, state_d;
    logic [10:0]      n_q, n_d;
    logic [31:0]      crc_q, crc_d;
    logic             giant_q, giant_d;
    logic             ucast_q, ucast_d;
    logic             bcast_q, bcast_d;
    logic [3:0][7:0]  sr_q, sr_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic [10:0]      frame_len_q, frame_len_d;
    logic [15:0]      ethertype_q, ethertype_d;
    logic [15:0]      good_q, good_d;
    logic [15:0]      bad_q, bad_d;

    logic             eof;
    logic             in_idle;
    logic [10:0]      n_base, n_inc;
    logic [31:0]      crc_base, crc_upd;
    logic [47:0]      mac_shift;
    logic [7:0]       addr_byte;
    logic             ucast_hit, bcast_hit;
    logic             drop_now;

    assign eof       = dv_prev_q & ~dv_s_q;
    assign in_idle   = (state_q == S_IDLE);
    // A byte taken in IDLE is byte 0 of a fresh frame, so it starts from cleared context.
    assign n_base    = in_idle ? 11'd0 : n_q;
    assign crc_base  = in_idle ? CRC_INIT : crc_q;
    assign n_inc     = (n_base == N_SAT) ? n_base : n_base + 11'd1;
    assign crc_upd   = crc_byte(crc_base, bus.byte_data);
    assign mac_shift = MAC_ADDR >> {3'd5 - n_base[2:0], 3'b000};
    assign addr_byte = mac_shift[7:0];
    assign ucast_hit = (bus.byte_data == addr_byte);
    assign bcast_hit = ACCEPT_BROADCAST && (bus.byte_data == 8'hFF);

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        crc_d        = crc_q;
        giant_d      = giant_q;
        ucast_d      = ucast_q;
        bcast_d      = bcast_q;
        sr_d         = sr_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_sof_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        frame_len_d  = frame_len_q;
        ethertype_d  = ethertype_q;
        drop_now     = 1'b0;

        case (state_q)
            S_IDLE, S_HEADER: begin
                if (in_idle) begin
                    n_d     = 11'd0;
                    crc_d   = CRC_INIT;
                    giant_d = 1'b0;
                    ucast_d = 1'b1;
                    bcast_d = 1'b1;
                end
                if (bus.byte_valid) begin
                    n_d   = n_inc;
                    crc_d = crc_upd;
                    sr_d  = {sr_q[2:0], bus.byte_data};
                    if (n_base < 11'd6) begin
                        ucast_d = (in_idle | ucast_q) & ucast_hit;
                        bcast_d = (in_idle | bcast_q) & bcast_hit;
                    end
                    if (n_base == 11'd12) ethertype_d[15:8] = bus.byte_data;
                    if (n_base == 11'd13) ethertype_d[7:0]  = bus.byte_data;
                    drop_now = (n_base == 11'd5) && !ucast_d && !bcast_d;
                    if (drop_now)                  state_d = S_DROP;
                    else if (n_base == 11'd13)     state_d = S_PAYLOAD;
                    else                           state_d = S_HEADER;
                end
                // An early EOF still earns a failing verdict once the address has matched.
                if (eof) begin
                    if (drop_now || n_d < 11'd6) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                        frame_ok_d   = 1'b0;
                        frame_len_d  = n_d;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.byte_valid) begin
                    n_d     = n_inc;
                    crc_d   = crc_upd;
                    sr_d    = {sr_q[2:0], bus.byte_data};
                    giant_d = giant_q | (n_inc > MAX_LEN_N);
                    if (n_q >= 11'd18 && !giant_d) begin
                        out_valid_d = 1'b1;
                        out_data_d  = sr_q[3];
                        out_sof_d   = (n_q == 11'd18);
                    end
                end
                if (eof) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                    frame_ok_d   = (crc_d == CRC_RESIDUE) && (n_d >= MIN_LEN_N) && !giant_d;
                    frame_len_d  = n_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DROP: begin
                if (eof) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (frame_done_q) begin
            if (frame_ok_q && good_q != 16'hFFFF) good_d = good_q + 16'd1;
            if (!frame_ok_q && bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_meta_q    <= 1'b0;
            dv_s_q       <= 1'b0;
            dv_prev_q    <= 1'b0;
            state_q      <= S_IDLE;
            n_q          <= 11'd0;
            crc_q        <= CRC_INIT;
            giant_q      <= 1'b0;
            ucast_q      <= 1'b0;
            bcast_q      <= 1'b0;
            sr_q         <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            out_sof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_len_q  <= 11'd0;
            ethertype_q  <= 16'd0;
            good_q       <= 16'd0;
            bad_q        <= 16'd0;
        end else begin
            dv_meta_q    <= bus.rx_dv;
            dv_s_q       <= dv_meta_q;
            dv_prev_q    <= dv_s_q;
            state_q      <= state_d;
            n_q          <= n_d;
            crc_q        <= crc_d;
            giant_q      <= giant_d;
            ucast_q      <= ucast_d;
            bcast_q      <= bcast_d;
            sr_q         <= sr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_len_q  <= frame_len_d;
            ethertype_q  <= ethertype_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.ethertype  = ethertype_q;
    assign bus.good_count = good_q;
    assign bus.bad_count  = bad_q;
    assign dbg_state_o    = state_q;

endmodule
